des_sbox_engine: RTL
====================

// Module: des_sbox_engine
// PURPOSE
//  Parametrised DES substitution stage: 48-bit expanded/key-mixed word in, 32-bit S1..S8 result out.
//  Evaluates LANES S-boxes per cycle, serialising over 8/LANES cycles; valid/ready on both sides.
//  Sits between key-mix XOR and the round-function XOR in the encryptor datapath.
//  Replaces eight standalone per-box lookups.
// PARAMETERS
//  LANES  4  S-boxes evaluated per clock; legal 1,2,4,8; anything else -> elaboration $error
// PORTS
//  clk        in   1   system clock, rising edge
//  n_rst      in   1   asynchronous reset, active low
//  in_valid   in   1   sub_in valid
//  in_ready   out  1   engine can accept sub_in
//  sub_in     in   48  S1 chunk = [47:42] ... S8 chunk = [5:0]
//  out_valid  out  1   sub_out valid, held until taken
//  out_ready  in   1   consumer takes sub_out
//  sub_out    out  32  S1 nibble = [31:28] ... S8 nibble = [3:0]
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - Lookup: 6-bit chunk b -> row = {b[5],b[0]}, col = b[4:1]; standard FIPS 46-3 S1..S8 tables.
//  - FSM IDLE/RUN/DONE; N = 8/LANES; group counter grp, width max(1,$clog2(N)).
//  - IDLE: in_ready=1. On in_valid: latch sub_in, grp<=0, ->RUN.
//  - RUN: in_ready=0. Each cycle: evaluate boxes grp*LANES .. grp*LANES+LANES-1, write nibbles into result reg.
//    grp==N-1 -> DONE, else grp++. LANES=8: exactly one RUN cycle.
//  - DONE: out_valid=1; sub_out stable from result reg. On out_ready -> IDLE.
//    Accept back-to-back only via IDLE: no new input taken in DONE.
//  - Latency: out_valid high N cycles after the accepting edge; throughput one word per N+2 cycles.
//  - Result reg is cleared only at reset. sub_out shows the last completed result (or 0 after reset) outside DONE.
//  - sub_in changes after acceptance are ignored (latched copy used).
//  - out_ready while not DONE: ignored. in_valid while not IDLE: ignored, no error.
//  - Reset (n_rst=0, any time incl. mid-RUN):
//    state=IDLE, grp=0, latched input=0, result=0.
//    Outputs: in_ready=1 (after reset releases), out_valid=0, busy=0, sub_out=0. Partial results discarded.
//  - No X propagation: all table cases fully covered; default branch drives 0.
// CONFIGURATION
//  SBOX_PERM_EN defined: sub_out = DES P-permutation of the concatenated S1..S8 result.
//    Applied combinationally on the result reg; no added latency.
//  SBOX_PERM_EN undefined: sub_out = raw concatenated S1..S8 nibbles.
// TESTING
//  (run each for LANES=1,2,4,8, macro off unless noted)
//  1 reset, sub_in=48'h0, in_valid 1 cycle -> out_valid after N cycles, sub_out=32'hEFA72C4D.
//  2 sub_in=48'hFFFF_FFFF_FFFF -> sub_out=32'hD9CE3DCB; hold out_ready=0 for 5 cycles -> out_valid and sub_out stay stable.
//  3 sub_in with only S2 chunk = 6'd1 (48'h0010_0000_0000) -> sub_out[27:24]=4'd3, other nibbles as in test 1.
//  4 assert n_rst low mid-RUN -> out_valid=0, busy=0, sub_out=0 immediately. New input after release -> correct result.
//  5 1000 random words, random in_valid/out_ready stalls -> every result matches C model, none dropped or duplicated,
//    in_ready low whenever busy.
//  6 SBOX_PERM_EN defined, random words -> sub_out equals P(model S-output) with same cycle latency as test 1.

Source files
------------

// File: rtl/des_sbox_engine_if.sv
// ---------------------------------------------------------------------------
// des_sbox_engine_if
// Purpose : Groups the handshake and data signals of the DES S-box engine.
//           The engine side uses the 'slave' modport; the producer/consumer
//           side (datapath or testbench) uses the 'master' modport.
// Signals :
//   in_valid   producer -> engine   sub_in is valid
//   in_ready   engine -> producer   engine can accept sub_in
//   sub_in     producer -> engine   48-bit key-mixed word, S1 chunk in [47:42]
//   out_valid  engine -> consumer   sub_out is valid, held until taken
//   out_ready  consumer -> engine   consumer takes sub_out
//   sub_out    engine -> consumer   32-bit result, S1 nibble in [31:28]
//   busy       engine -> any        engine is not idle
// ---------------------------------------------------------------------------
interface des_sbox_engine_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] sub_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sub_out;
  logic        busy;

  modport slave (
    input  in_valid,
    input  sub_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sub_out,
    output busy
  );

  modport master (
    output in_valid,
    output sub_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sub_out,
    input  busy
  );
endinterface

// File: rtl/des_sbox_engine.sv
// ---------------------------------------------------------------------------
// des_sbox_engine
// Purpose : DES substitution stage. Takes the 48-bit expanded, key-mixed word
//           and produces the 32-bit S1..S8 output, evaluating LANES S-boxes
//           per clock and serialising over 8/LANES clocks.
// Parameter:
//   LANES      S-boxes evaluated per clock, legal values 1, 2, 4, 8
// Ports   :
//   clk        system clock, rising edge
//   n_rst      asynchronous reset, active low
//   bus        des_sbox_engine_if.slave (in_valid/in_ready/sub_in,
//              out_valid/out_ready/sub_out, busy)
// Config  :
//   SBOX_PERM_EN  when defined, sub_out carries the DES P-permutation of the
//                 S1..S8 result (combinational, no extra latency); otherwise
//                 sub_out is the raw concatenated S-box nibbles.
// ---------------------------------------------------------------------------
module des_sbox_engine #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  des_sbox_engine_if.slave   bus
);

  localparam bit LANES_OK = (LANES == 1) || (LANES == 2) || (LANES == 4) || (LANES == 8);
  localparam int N        = LANES_OK ? (8 / LANES) : 1;
  localparam int GW       = (N > 1) ? $clog2(N) : 1;

  generate
    if (!LANES_OK) begin : g_bad_lanes
      $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [GW-1:0] r_grp;
  logic [47:0]   r_in;
  logic [31:0]   r_result;
  logic [31:0]   w_nextResult;
  logic [31:0]   w_subOut;

  // One FIPS 46-3 S-box lookup. Each table row is packed as 16 nibbles with
  // column 0 in the most significant nibble; box 0 is S1.
  function automatic logic [3:0] sboxLookup(input logic [2:0] box, input logic [5:0] b);
    logic [63:0] rowv;
    logic [63:0] sh;
    case ({box, b[5], b[0]})
      5'd0:  rowv = 64'hE4D12FB83A6C5907;
      5'd1:  rowv = 64'h0F74E2D1A6CB9538;
      5'd2:  rowv = 64'h41E8D62BFC973A50;
      5'd3:  rowv = 64'hFC8249175B3EA06D;
      5'd4:  rowv = 64'hF18E6B34972DC05A;
      5'd5:  rowv = 64'h3D47F28EC01A69B5;
      5'd6:  rowv = 64'h0E7BA4D158C6932F;
      5'd7:  rowv = 64'hD8A13F42B67C05E9;
      5'd8:  rowv = 64'hA09E63F51DC7B428;
      5'd9:  rowv = 64'hD709346A285ECBF1;
      5'd10: rowv = 64'hD6498F30B12C5AE7;
      5'd11: rowv = 64'h1AD069874FE3B52C;
      5'd12: rowv = 64'h7DE3069A1285BC4F;
      5'd13: rowv = 64'hD8B56F03472C1AE9;
      5'd14: rowv = 64'hA690CB7DF13E5284;
      5'd15: rowv = 64'h3F06A1D8945BC72E;
      5'd16: rowv = 64'h2C417AB6853FD0E9;
      5'd17: rowv = 64'hEB2C47D150FA3986;
      5'd18: rowv = 64'h421BAD78F9C5630E;
      5'd19: rowv = 64'hB8C71E2D6F09A453;
      5'd20: rowv = 64'hC1AF92680D34E75B;
      5'd21: rowv = 64'hAF427C9561DE0B38;
      5'd22: rowv = 64'h9EF528C3704A1DB6;
      5'd23: rowv = 64'h432C95FABE17608D;
      5'd24: rowv = 64'h4B2EF08D3C975A61;
      5'd25: rowv = 64'hD0B7491AE35C2F86;
      5'd26: rowv = 64'h14BDC37EAF680592;
      5'd27: rowv = 64'h6BD814A7950FE23C;
      5'd28: rowv = 64'hD2846FB1A93E50C7;
      5'd29: rowv = 64'h1FD8A374C56B0E92;
      5'd30: rowv = 64'h7B419CE206ADF358;
      5'd31: rowv = 64'h21E74A8DFC90356B;
      default: rowv = 64'h0;
    endcase
    sh = rowv >> {4'd15 - b[4:1], 2'b00};
    return sh[3:0];
  endfunction

  // Evaluate the LANES boxes of the current group and merge their nibbles
  // into the running result; nibbles of other groups keep their old value.
  always_comb begin
    w_nextResult = r_result;
    for (int l = 0; l < LANES; l++) begin
      int          boxIdx;
      logic [47:0] shifted;
      boxIdx  = int'(r_grp) * LANES + l;
      shifted = r_in >> (6 * (7 - boxIdx));
      w_nextResult[(28 - 4 * boxIdx) +: 4] = sboxLookup(boxIdx[2:0], shifted[5:0]);
    end
  end

  // Control FSM: IDLE accepts a word, RUN walks the groups, DONE holds the
  // result until the consumer takes it. New input is only taken in IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= S_IDLE;
      r_grp    <= '0;
      r_in     <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_in    <= bus.sub_in;
            r_grp   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_result <= w_nextResult;
          if (r_grp == GW'(N - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_grp <= r_grp + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SBOX_PERM_EN
  // DES P table, 1-based with bit 1 being the MSB of the S-box output.
  localparam int P_TAB [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                                 1, 15, 23, 26,  5, 18, 31, 10,
                                 2,  8, 24, 14, 32, 27,  3,  9,
                                19, 13, 30,  6, 22, 11,  4, 25};
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_perm
      assign w_subOut[31 - gi] = r_result[32 - P_TAB[gi]];
    end
  endgenerate
`else
  assign w_subOut = r_result;
`endif

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.sub_out   = w_subOut;

endmodule
